// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: shifts WIDTH-bit words out MSB-first over a valid/ready handshake.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module bit_serializer #(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
   logic par;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             xfer;

   // done marks the final bit cycle, which is exactly when a new word may be accepted.
   assign din_ready = reset_n && (state == IDLE || done);
   assign xfer      = din_valid && din_ready;

   // NOTE: every register here uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         x_out   <= IDLE_LEVEL;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef SER_PARITY_EN
         par     <= 1'b0;
`endif
      end else if (xfer) begin
         state   <= SHIFT;
         shreg   <= din;
         cnt     <= CW'(WIDTH);
         x_out   <= din[WIDTH-1];
         x_valid <= 1'b1;
         busy    <= 1'b1;
         done    <= 1'b0;
`ifdef SER_PARITY_EN
         par     <= ^din;
`endif
      end else if (state == SHIFT) begin
         shreg <= {shreg[WIDTH-2:0], 1'b0};
         cnt   <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
`ifdef SER_PARITY_EN
            state <= PARITY;
            x_out <= par;
            done  <= 1'b1;
`else
            state   <= IDLE;
            x_out   <= IDLE_LEVEL;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`endif
         end else begin
            // Outputs are precomputed one edge ahead so they leave the flops glitch-free.
            x_out <= shreg[WIDTH-2];
`ifndef SER_PARITY_EN
            done  <= (cnt == CW'(2));
`endif
         end
      end
`ifdef SER_PARITY_EN
      else if (state == PARITY) begin
         state   <= IDLE;
         x_out   <= IDLE_LEVEL;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH=8, IDLE_LEVEL=0).
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       din_ready, x_out, x_valid, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   bit_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .x_out     (x_out),
      .x_valid   (x_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".x_valid"}, 32'(x_valid), 32'd0);
      check({tag, ".x_out"}, 32'(x_out), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
   endtask

   logic [15:0] pat;
   logic [7:0]  w;

   initial begin
      // Reset values, checked while reset is held.
      @(negedge clk);
      check_idle("rst");
      check("rst.din_ready", 32'(din_ready), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("rst_rel.din_ready", 32'(din_ready), 32'd1);

`ifndef SER_PARITY_EN
      // Single word 8'hB4.
      @(negedge clk);
      w = 8'hB4;
      din = w; din_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("single.bit%0d", i), 32'(x_out), 32'(w[7-i]));
         check($sformatf("single.valid%0d", i), 32'(x_valid), 32'd1);
         check($sformatf("single.done%0d", i), 32'(done), 32'(i == 7));
         if (i == 0) din_valid = 1'b0;
      end
      @(negedge clk);
      check_idle("single.after");
      check("single.after.din_ready", 32'(din_ready), 32'd1);

      // Back-to-back 8'hFF then 8'h00.
      pat = 16'hFF00;
      din = 8'hFF; din_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("b2b.bit%0d", i), 32'(x_out), 32'(pat[15-i]));
         check($sformatf("b2b.valid%0d", i), 32'(x_valid), 32'd1);
         check($sformatf("b2b.done%0d", i), 32'(done), 32'(i == 7 || i == 15));
         if (i == 3) check("b2b.ready_mid", 32'(din_ready), 32'd0);
         if (i == 7) check("b2b.ready_last", 32'(din_ready), 32'd1);
         if (i == 0) din = 8'h00;
         if (i == 8) din_valid = 1'b0;
      end
      @(negedge clk);
      check_idle("b2b.after");

      // Word held while busy: 8'h3C offered during bit 3 of 8'hA5.
      pat = 16'hA53C;
      din = 8'hA5; din_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("hold.bit%0d", i), 32'(x_out), 32'(pat[15-i]));
         check($sformatf("hold.done%0d", i), 32'(done), 32'(i == 7 || i == 15));
         if (i == 0) din_valid = 1'b0;
         if (i == 3) begin
            din = 8'h3C; din_valid = 1'b1;
            #1 check("hold.ready_busy", 32'(din_ready), 32'd0);
         end
         if (i == 7) check("hold.ready_last", 32'(din_ready), 32'd1);
         if (i == 8) begin
            din_valid = 1'b0;
            din = 8'hFF;
         end
      end
      @(negedge clk);
      check_idle("hold.after");
`else
      // Parity: 8'hB4 (parity 0) then 8'h07 (parity 1), back-to-back period 9.
      pat = 16'hB407;
      din = 8'hB4; din_valid = 1'b1;
      for (int i = 0; i < 18; i++) begin
         logic e;
         if (i < 8)       e = pat[15-i];
         else if (i == 8) e = 1'b0;
         else if (i < 17) e = pat[7-(i-9)];
         else             e = 1'b1;
         @(negedge clk);
         check($sformatf("par.bit%0d", i), 32'(x_out), 32'(e));
         check($sformatf("par.valid%0d", i), 32'(x_valid), 32'd1);
         check($sformatf("par.done%0d", i), 32'(done), 32'(i == 8 || i == 17));
         if (i == 7) check("par.ready_lastdata", 32'(din_ready), 32'd0);
         if (i == 8) check("par.ready_parity", 32'(din_ready), 32'd1);
         if (i == 0) din = 8'h07;
         if (i == 9) din_valid = 1'b0;
      end
      @(negedge clk);
      check_idle("par.after");
`endif

      // Reset asserted during bit 4 of 8'hB4.
      w = 8'hB4;
      din = w; din_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("mrst.bit%0d", i), 32'(x_out), 32'(w[7-i]));
         if (i == 0) din_valid = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      check_idle("mrst.now");
      check("mrst.din_ready", 32'(din_ready), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("mrst.quiet%0d", i), 32'(x_valid), 32'd0);
      end
      check("mrst.x_out", 32'(x_out), 32'd0);
      check("mrst.ready", 32'(din_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
